// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequencing FSM for a direct-mapped, write-through, no-write-allocate cache.
// The controller owns the tag memory port and the valid bits. It also drives the data memory
// write control and the main-memory request channel. It accepts one CPU access at a time and
// resolves it as a hit or a miss. A read miss refills the whole line. Every write goes through
// to main memory. A flush walks every line and invalidates it.
module dm_cache_ctrl #(
  parameter int INDEX_LENGTH  = 4,
  parameter int TAG_LENGTH    = 8,
  parameter int OFFSET_LENGTH = 2,
  parameter int ADDR_WIDTH    = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH
) (
  input  logic                     clk,
  input  logic                     reset,
  // CPU request / response
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic                     cpu_req_write,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  output logic                     cpu_resp_valid,
  output logic                     cpu_resp_hit,
  // Flush control
  input  logic                     flush_req,
  output logic                     flush_busy,
  // Tag memory port
  output logic                     tag_write,
  output logic [INDEX_LENGTH-1:0]  tag_index,
  output logic [TAG_LENGTH-1:0]    tag_wdata,
  input  logic [TAG_LENGTH-1:0]    tag_rdata,
  // Data memory write control
  output logic                     data_write,
  output logic [INDEX_LENGTH-1:0]  data_index,
  output logic [OFFSET_LENGTH-1:0] data_offset,
  output logic                     data_src_mem,
  // Main-memory request channel
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_resp_valid
);

  localparam int NUM_CACHE_LINES = 1 << INDEX_LENGTH;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOOKUP      = 3'd1,
    ST_REFILL_REQ  = 3'd2,
    ST_REFILL_WAIT = 3'd3,
    ST_WT_REQ      = 3'd4,
    ST_WT_WAIT     = 3'd5,
    ST_RESP        = 3'd6,
    ST_FLUSH       = 3'd7
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;          // latched CPU word address
  logic                       write_q, write_d;        // latched access direction
  logic                       hit_q, hit_d;            // lookup result reported in RESP
  logic [OFFSET_LENGTH-1:0]   cnt_q, cnt_d;            // refill word counter
  logic [INDEX_LENGTH-1:0]    flush_cnt_q, flush_cnt_d;
  logic [NUM_CACHE_LINES-1:0] valid_q, valid_d;

  // Address fields of the latched request and of the incoming CPU address
  logic [TAG_LENGTH-1:0]      addr_tag_s;
  logic [INDEX_LENGTH-1:0]    addr_idx_s;
  logic [OFFSET_LENGTH-1:0]   addr_off_s;
  logic [INDEX_LENGTH-1:0]    cpu_idx_s;
  logic                       lookup_hit_s;

  assign addr_tag_s   = addr_q[ADDR_WIDTH-1 -: TAG_LENGTH];
  assign addr_idx_s   = addr_q[OFFSET_LENGTH +: INDEX_LENGTH];
  assign addr_off_s   = addr_q[OFFSET_LENGTH-1:0];
  assign cpu_idx_s    = cpu_addr[OFFSET_LENGTH +: INDEX_LENGTH];
  // The tag arrives one cycle after the index is presented, which is the LOOKUP cycle.
  assign lookup_hit_s = valid_q[addr_idx_s] && (tag_rdata == addr_tag_s);

  // State and datapath registers; asynchronous reset returns to an empty, idle cache
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      flush_cnt_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and output decode; every output idles at 0 unless its state drives it
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    write_d        = write_q;
    hit_d          = hit_q;
    cnt_d          = cnt_q;
    flush_cnt_d    = flush_cnt_q;
    valid_d        = valid_q;

    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_hit   = 1'b0;
    flush_busy     = 1'b0;
    tag_write      = 1'b0;
    tag_index      = '0;
    tag_wdata      = '0;
    data_write     = 1'b0;
    data_index     = '0;
    data_offset    = '0;
    data_src_mem   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_addr       = '0;

    case (state_q)
      ST_IDLE: begin
        // A flush request wins over a CPU access in the same cycle.
        cpu_req_ready = !flush_req;
        if (flush_req) begin
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else if (cpu_req_valid) begin
          addr_d    = cpu_addr;
          write_d   = cpu_req_write;
          tag_index = cpu_idx_s;
          state_d   = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOOKUP: begin
        tag_index = addr_idx_s;
        hit_d     = lookup_hit_s;
        if (write_q) begin
          // A write hit updates the cached word. A write miss does not allocate.
          // Both cases then write through.
          if (lookup_hit_s) begin
            data_write   = 1'b1;
            data_index   = addr_idx_s;
            data_offset  = addr_off_s;
            data_src_mem = 1'b0;
          end else begin
            data_write = 1'b0;
          end
          state_d = ST_WT_REQ;
        end else if (lookup_hit_s) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = '0;
          state_d = ST_REFILL_REQ;
        end
      end

      ST_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b0;
        mem_addr      = {addr_tag_s, addr_idx_s, cnt_q};
        if (mem_req_ready) begin
          state_d = ST_REFILL_WAIT;
        end else begin
          state_d = ST_REFILL_REQ;
        end
      end

      ST_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          data_write   = 1'b1;
          data_src_mem = 1'b1;
          data_index   = addr_idx_s;
          data_offset  = cnt_q;
          if (cnt_q == '1) begin
            // The last word completes the line. The tag and the valid bit are set
            // alongside that final data write.
            tag_write            = 1'b1;
            tag_index            = addr_idx_s;
            tag_wdata            = addr_tag_s;
            valid_d[addr_idx_s]  = 1'b1;
            state_d              = ST_RESP;
          end else begin
            cnt_d   = cnt_q + OFFSET_LENGTH'(1);
            state_d = ST_REFILL_REQ;
          end
        end else begin
          state_d = ST_REFILL_WAIT;
        end
      end

      ST_WT_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_addr      = addr_q;
        if (mem_req_ready) begin
          state_d = ST_WT_WAIT;
        end else begin
          state_d = ST_WT_REQ;
        end
      end

      ST_WT_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WT_WAIT;
        end
      end

      ST_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_hit   = hit_q;
        state_d        = ST_IDLE;
      end

      ST_FLUSH: begin
        // Invalidate one line per cycle. Stop at the top index so the counter never wraps.
        flush_busy            = 1'b1;
        tag_write             = 1'b1;
        tag_index             = flush_cnt_q;
        tag_wdata             = '0;
        valid_d[flush_cnt_q]  = 1'b0;
        if (flush_cnt_q == '1) begin
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + INDEX_LENGTH'(1);
          state_d     = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed bench for dm_cache_ctrl.
// The bench provides a tag memory with one-cycle read latency. It also provides a main memory
// that answers one cycle after it accepts a request, and whose ready can be held low.
// A negedge monitor counts write strobes and logs every accepted memory request.
module tb_dm_cache_ctrl;

  localparam int IL = 4;
  localparam int TL = 8;
  localparam int OL = 2;
  localparam int AW = TL + IL + OL;

  logic          clk;
  logic          reset;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic          cpu_req_write;
  logic [AW-1:0] cpu_addr;
  logic          cpu_resp_valid;
  logic          cpu_resp_hit;
  logic          flush_req;
  logic          flush_busy;
  logic          tag_write;
  logic [IL-1:0] tag_index;
  logic [TL-1:0] tag_wdata;
  logic [TL-1:0] tag_rdata;
  logic          data_write;
  logic [IL-1:0] data_index;
  logic [OL-1:0] data_offset;
  logic          data_src_mem;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_write;
  logic [AW-1:0] mem_addr;
  logic          mem_resp_valid;

  logic          hold_ready;

  int n_checks;
  int n_errors;

  dm_cache_ctrl #(
    .INDEX_LENGTH (IL),
    .TAG_LENGTH   (TL),
    .OFFSET_LENGTH(OL),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_write (cpu_req_write),
    .cpu_addr      (cpu_addr),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_hit  (cpu_resp_hit),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .tag_write     (tag_write),
    .tag_index     (tag_index),
    .tag_wdata     (tag_wdata),
    .tag_rdata     (tag_rdata),
    .data_write    (data_write),
    .data_index    (data_index),
    .data_offset   (data_offset),
    .data_src_mem  (data_src_mem),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_addr      (mem_addr),
    .mem_resp_valid(mem_resp_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag memory model: synchronous write, registered read
  logic [TL-1:0] tag_mem_r [0:(1<<IL)-1];
  always @(posedge clk) begin
    if (tag_write) tag_mem_r[tag_index] <= tag_wdata;
    tag_rdata <= tag_mem_r[tag_index];
  end

  // Main memory model: accepts when not held, answers on the following cycle
  assign mem_req_ready = mem_req_valid && !hold_ready;
  always @(posedge clk or posedge reset) begin
    if (reset) mem_resp_valid <= 1'b0;
    else       mem_resp_valid <= mem_req_valid && mem_req_ready;
  end

  // Monitor: write-strobe counters and a log of accepted memory requests {write, addr}
  int               n_dw_mem;
  int               n_dw_cpu;
  int               n_tw;
  logic [IL-1:0]    last_tidx;
  logic [TL-1:0]    last_twdata;
  logic [AW:0]      mreq_q [$];
  initial begin
    n_dw_mem = 0; n_dw_cpu = 0; n_tw = 0; last_tidx = '0; last_twdata = '0;
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (data_write &&  data_src_mem) n_dw_mem <= n_dw_mem + 1;
      if (data_write && !data_src_mem) n_dw_cpu <= n_dw_cpu + 1;
      if (tag_write) begin
        n_tw        <= n_tw + 1;
        last_tidx   <= tag_index;
        last_twdata <= tag_wdata;
      end
      if (mem_req_valid && mem_req_ready) mreq_q.push_back({mem_req_write, mem_addr});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one access in IDLE and return just after the accepting edge
  task automatic start_access(input logic wr, input logic [AW-1:0] addr);
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_addr      = addr;
    #1;
    check_eq("req_ready", {31'd0, cpu_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
  endtask

  // Wait for the response pulse; lat = negedges counted since the accept edge
  task automatic wait_resp(output logic hit, output int lat);
    bit done;
    done = 1'b0;
    hit  = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 300 && !done; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin
        hit  = cpu_resp_hit;
        lat  = i;
        done = 1'b1;
      end
    end
    if (!done) check_eq("resp_timeout", 32'd0, 32'd1);
  endtask

  logic hit;
  int   lat;
  int   qb, dwm0, dwc0, tw0, nbusy;
  logic [AW-1:0] exp_a;

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_addr = '0;
    flush_req = 1'b0; hold_ready = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state: only cpu_req_ready is high
    check_eq("reset_outs",
             {24'd0, cpu_req_ready, cpu_resp_valid, cpu_resp_hit, flush_busy,
              tag_write, data_write, mem_req_valid, mem_req_write}, 32'h80);
    check_eq("reset_mem_addr", {18'd0, mem_addr}, 32'd0);
    reset = 1'b0;

    // Cold read 0x1A4: miss, 4 refill reads, tag 0x06 at index 9
    qb = mreq_q.size(); dwm0 = n_dw_mem; tw0 = n_tw;
    start_access(1'b0, 14'h1A4);
    wait_resp(hit, lat);
    check_eq("cold_hit", {31'd0, hit}, 32'd0);
    check_eq("cold_nreq", mreq_q.size() - qb, 32'd4);
    for (int k = 0; k < 4; k++) begin
      exp_a = 14'h1A4 + 14'(k);
      check_eq($sformatf("cold_req%0d", k), {17'd0, mreq_q[qb+k]}, {17'd0, 1'b0, exp_a});
    end
    check_eq("cold_dwrites", n_dw_mem - dwm0, 32'd4);
    check_eq("cold_twrites", n_tw - tw0, 32'd1);
    check_eq("cold_tag_idx", {28'd0, last_tidx}, 32'd9);
    check_eq("cold_tag_val", {24'd0, last_twdata}, 32'h06);

    // Repeat read 0x1A5: hit, no memory traffic, response 2 cycles after accept
    qb = mreq_q.size();
    start_access(1'b0, 14'h1A5);
    wait_resp(hit, lat);
    check_eq("rhit_hit", {31'd0, hit}, 32'd1);
    check_eq("rhit_lat", lat, 32'd2);
    check_eq("rhit_nreq", mreq_q.size() - qb, 32'd0);

    // Write hit 0x1A6: one CPU data write, then one write-through
    qb = mreq_q.size(); dwc0 = n_dw_cpu; tw0 = n_tw;
    start_access(1'b1, 14'h1A6);
    wait_resp(hit, lat);
    check_eq("whit_hit", {31'd0, hit}, 32'd1);
    check_eq("whit_dwrites", n_dw_cpu - dwc0, 32'd1);
    check_eq("whit_nreq", mreq_q.size() - qb, 32'd1);
    check_eq("whit_req", {17'd0, mreq_q[qb]}, {17'd0, 1'b1, 14'h1A6});
    check_eq("whit_twrites", n_tw - tw0, 32'd0);

    // Write miss 0x2B0: write-through only
    qb = mreq_q.size(); dwc0 = n_dw_cpu; dwm0 = n_dw_mem; tw0 = n_tw;
    start_access(1'b1, 14'h2B0);
    wait_resp(hit, lat);
    check_eq("wmiss_hit", {31'd0, hit}, 32'd0);
    check_eq("wmiss_dwrites", (n_dw_cpu - dwc0) + (n_dw_mem - dwm0), 32'd0);
    check_eq("wmiss_twrites", n_tw - tw0, 32'd0);
    check_eq("wmiss_nreq", mreq_q.size() - qb, 32'd1);
    check_eq("wmiss_req", {17'd0, mreq_q[qb]}, {17'd0, 1'b1, 14'h2B0});

    // Refill with mem_req_ready held low: request holds steady, no data writes
    hold_ready = 1'b1;
    qb = mreq_q.size(); dwm0 = n_dw_mem;
    start_access(1'b0, 14'h0C8);
    @(negedge clk);  // LOOKUP
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("stall_valid%0d", k), {31'd0, mem_req_valid}, 32'd1);
      check_eq($sformatf("stall_addr%0d", k), {17'd0, mem_req_write, mem_addr}, {17'd0, 1'b0, 14'h0C8});
    end
    check_eq("stall_dwrites", n_dw_mem - dwm0, 32'd0);
    @(posedge clk);
    #1;
    hold_ready = 1'b0;
    wait_resp(hit, lat);
    check_eq("stall_hit", {31'd0, hit}, 32'd0);
    check_eq("stall_nreq", mreq_q.size() - qb, 32'd4);
    check_eq("stall_req3", {17'd0, mreq_q[qb+3]}, {17'd0, 1'b0, 14'h0CB});

    // Flush and CPU request together: flush wins and takes 16 cycles
    qb = mreq_q.size(); tw0 = n_tw;
    @(negedge clk);
    flush_req = 1'b1; cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_addr = 14'h1A4;
    #1;
    check_eq("flush_ready_low", {31'd0, cpu_req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush_req = 1'b0; cpu_req_valid = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flush_busy) nbusy++;
      else break;
    end
    check_eq("flush_cycles", nbusy, 32'd16);
    check_eq("flush_twrites", n_tw - tw0, 32'd16);
    check_eq("flush_last_idx", {28'd0, last_tidx}, 32'd15);
    check_eq("flush_last_wdata", {24'd0, last_twdata}, 32'd0);
    check_eq("flush_nreq", mreq_q.size() - qb, 32'd0);
    start_access(1'b0, 14'h1A4);
    wait_resp(hit, lat);
    check_eq("postflush_hit", {31'd0, hit}, 32'd0);
    check_eq("postflush_nreq", mreq_q.size() - qb, 32'd4);

    // Reset during REFILL_WAIT: immediate idle, lines invalidated
    start_access(1'b0, 14'h3F0);
    @(negedge clk);  // LOOKUP
    @(negedge clk);  // REFILL_REQ, accepted at next edge
    @(negedge clk);  // REFILL_WAIT with the first word arriving
    check_eq("rst_in_wait", {30'd0, data_write, data_src_mem}, 32'd3);
    reset = 1'b1;
    #1;
    check_eq("rst_outs",
             {24'd0, cpu_req_ready, cpu_resp_valid, cpu_resp_hit, flush_busy,
              tag_write, data_write, mem_req_valid, mem_req_write}, 32'h80);
    @(negedge clk);
    reset = 1'b0;
    qb = mreq_q.size();
    start_access(1'b0, 14'h3F0);
    wait_resp(hit, lat);
    check_eq("rst_reread_hit", {31'd0, hit}, 32'd0);
    check_eq("rst_reread_nreq", mreq_q.size() - qb, 32'd4);
    qb = mreq_q.size();
    start_access(1'b0, 14'h1A5);
    wait_resp(hit, lat);
    check_eq("rst_other_hit", {31'd0, hit}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
